// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: controller states and
// the run-mode encoding latched at start.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_t;

    localparam logic ONE_SHOT = 1'b0;
    localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/countdown_timer.sv
// Programmable down-counter driven by an upstream carry pulse. Counts a loaded
// value down to expiry, pulsing done once, in one-shot or auto-reload mode.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    timer_state_t     r_state_reg, r_state_next;
    logic [WIDTH-1:0] r_count_reg, r_count_next;
    logic [WIDTH-1:0] r_reload_reg, r_reload_next;
    logic             r_mode_reg, r_mode_next;
    logic             r_done_reg, r_done_next;

    logic             w_last_tick;

    assign w_last_tick = (r_count_reg == WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_reg  <= IDLE;
            r_count_reg  <= '0;
            r_reload_reg <= '0;
            r_mode_reg   <= ONE_SHOT;
            r_done_reg   <= 1'b0;
        end else begin
            r_state_reg  <= r_state_next;
            r_count_reg  <= r_count_next;
            r_reload_reg <= r_reload_next;
            r_mode_reg   <= r_mode_next;
            r_done_reg   <= r_done_next;
        end
    end

    // Priority is stop > start > hold > tick; done defaults low so it can
    // only ever last one cycle per expiry.
    always_comb begin
        r_state_next  = r_state_reg;
        r_count_next  = r_count_reg;
        r_reload_next = r_reload_reg;
        r_mode_next   = r_mode_reg;
        r_done_next   = 1'b0;

        if (stop) begin
            r_state_next = IDLE;
            r_count_next = '0;
        end else if (start) begin
            r_reload_next = load_val;
            r_mode_next   = auto_reload;
            r_count_next  = load_val;
            if (load_val == '0) begin
                // Zero load expires immediately and never reloads.
                r_state_next = IDLE;
                r_done_next  = 1'b1;
            end else begin
                r_state_next = RUN;
            end
        end else begin
            case (r_state_reg)
                RUN: begin
                    if (hold) begin
                        r_state_next = HOLD;
                    end else if (tick) begin
                        if (w_last_tick) begin
                            r_done_next = 1'b1;
                            if (r_mode_reg == PERIODIC) begin
                                r_count_next = r_reload_reg;
                            end else begin
                                r_count_next = '0;
                                r_state_next = IDLE;
                            end
                        end else if (r_count_reg != '0) begin
                            r_count_next = r_count_reg - WIDTH'(1);
                        end
                    end
                end
                HOLD: begin
                    // The release cycle itself does not count a tick.
                    if (!hold) begin
                        r_state_next = RUN;
                    end
                end
                default: begin
                    r_state_next = IDLE;
                end
            endcase
        end
    end

    assign out  = r_count_reg;
    assign busy = (r_state_reg != IDLE);
    assign done = r_done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic, every
// cycle compared against a rule-level reference model.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset, tick, start, stop, hold, auto_reload;
    logic [7:0] load_val;
    logic [7:0] out;
    logic       busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    bit         m_active, m_held, m_periodic, m_done;
    int         m_out, m_reload;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load_val   (load_val),
        .start      (start),
        .stop       (stop),
        .hold       (hold),
        .auto_reload(auto_reload),
        .out        (out),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Applies the behavioural rules to the inputs present at this edge.
    function automatic void model_edge();
        if (reset) begin
            m_active = 0; m_held = 0; m_periodic = 0; m_done = 0;
            m_out = 0; m_reload = 0;
            return;
        end
        m_done = 0;
        if (stop) begin
            m_active = 0; m_held = 0; m_out = 0;
        end else if (start) begin
            m_out = load_val;
            m_reload = load_val;
            m_periodic = auto_reload;
            m_held = 0;
            if (load_val == 0) begin
                m_active = 0;
                m_done = 1;
            end else begin
                m_active = 1;
            end
        end else if (m_active) begin
            if (m_held) begin
                m_held = hold;
            end else if (hold) begin
                m_held = 1;
            end else if (tick) begin
                if (m_out - 1 > 0) begin
                    m_out = m_out - 1;
                end else begin
                    m_done = 1;
                    if (m_periodic) m_out = m_reload;
                    else begin
                        m_out = 0;
                        m_active = 0;
                    end
                end
            end
        end
    endfunction

    task automatic step(input bit t, input bit st, input bit sp, input bit h,
                        input bit ar, input bit rs, input int lv);
        tick = t; start = st; stop = sp; hold = h;
        auto_reload = ar; reset = rs; load_val = 8'(lv);
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check("out",  int'(out),  m_out);
        check("busy", int'(busy), int'(m_active));
        check("done", int'(done), int'(m_done));
    endtask

    task automatic idle_step(input bit t);
        step(t, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int done_cnt;
        int zero_cnt;
        int first_done;
        int last_done;
        bit hold_lvl;

        tick = 0; start = 0; stop = 0; hold = 0; auto_reload = 0;
        reset = 1; load_val = 0;

        // reset state
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("rst_out", int'(out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // one-shot 5 with continuous tick
        step(1, 1, 0, 0, 0, 0, 5);
        check("os_load", int'(out), 5);
        check("os_busy", int'(busy), 1);
        for (int i = 1; i <= 5; i++) begin
            idle_step(1);
            check("os_out", int'(out), 5 - i);
            check("os_done", int'(done), (i == 5) ? 1 : 0);
        end
        check("os_busy_end", int'(busy), 0);
        idle_step(1);
        check("os_done_clear", int'(done), 0);

        // periodic 3, tick every 2nd cycle, 9 ticks
        step(0, 1, 0, 0, 1, 0, 3);
        done_cnt = 0; zero_cnt = 0; first_done = -1; last_done = -1;
        for (int i = 0; i < 18; i++) begin
            idle_step(i % 2 == 1);
            if (out == 0) zero_cnt++;
            if (done) begin
                if (last_done >= 0) check("per_spacing", i - last_done, 6);
                last_done = i;
                done_cnt++;
            end
        end
        check("per_pulses", done_cnt, 3);
        check("per_no_zero", zero_cnt, 0);
        step(0, 0, 1, 0, 0, 0, 0);

        // hold for 4 cycles mid-count; the release cycle also loses its tick
        step(1, 1, 0, 0, 0, 0, 6);
        idle_step(1);
        idle_step(1);
        check("hold_pre", int'(out), 4);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, 0, 0, 0);
            check("hold_frozen", int'(out), 4);
        end
        first_done = -1;
        for (int i = 0; i < 30 && first_done < 0; i++) begin
            idle_step(1);
            if (done) first_done = i;
        end
        // 4 remaining ticks after one uncounted release cycle
        check("hold_done_at", first_done, 4);

        // zero load with auto_reload: single forced one-shot pulse
        step(1, 1, 0, 0, 1, 0, 0);
        check("zero_done", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            idle_step(1);
            if (done) done_cnt++;
        end
        check("zero_no_more", done_cnt, 0);

        // stop on the expiring tick
        step(1, 1, 0, 0, 0, 0, 3);
        idle_step(1);
        idle_step(1);
        check("stop_pre", int'(out), 1);
        step(1, 0, 1, 0, 0, 0, 0);
        check("stop_done", int'(done), 0);
        check("stop_out", int'(out), 0);
        check("stop_busy", int'(busy), 0);

        // reset on the expiring tick
        step(1, 1, 0, 0, 0, 0, 2);
        idle_step(1);
        check("rst_pre", int'(out), 1);
        step(1, 0, 0, 0, 0, 1, 0);
        check("rstmid_done", int'(done), 0);
        check("rstmid_out", int'(out), 0);
        check("rstmid_busy", int'(busy), 0);

        // restart with a coincident tick
        step(1, 1, 0, 0, 0, 0, 5);
        idle_step(1); idle_step(1); idle_step(1);
        check("rs_pre", int'(out), 2);
        step(1, 1, 0, 0, 0, 0, 7);
        check("rs_out", int'(out), 7);
        check("rs_busy", int'(busy), 1);

        // random traffic against the model
        hold_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            int lv;
            if ($urandom_range(0, 7) == 0) hold_lvl = ~hold_lvl;
            lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 5));
            step($urandom_range(0, 2) != 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 59) == 0,
                 hold_lvl,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 199) == 0,
                 lv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
